// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types for the Ibex-to-SRAM port arbiter.
//
//   owner_e   : which Ibex port owns a granted transaction.
//   rsp_tag_t : one-deep response tag. It is captured on every grant and
//               consumed by the response mux one cycle later.
//   in_window : address decode helper used to decide whether a granted
//               request is forwarded to the SRAM or answered with an error.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    // Bit positions of each requester in the arbiter request/grant vectors.
    localparam int unsigned PortInstr = 0;
    localparam int unsigned PortData  = 1;

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;  // a response is due this cycle
        owner_e owner;  // port that receives the response
        logic   err;    // request was outside the SRAM window
    } rsp_tag_t;

    localparam rsp_tag_t RspTagIdle = '{valid: 1'b0, owner: OwnerInstr, err: 1'b0};

    // An address hits the SRAM when the bits outside the decoded range
    // match the window base exactly.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter with a combinational grant.
//
//   Ports
//     clk_i       : clock, pointer updates on the rising edge
//     rst_ni      : asynchronous active-low reset
//     req_i[1:0]  : requests, bit 0 = instr, bit 1 = data
//     gnt_o[1:0]  : one-hot (or zero) grant, same cycle as the request
//
//   The pointer remembers the winner of the last contended cycle. It only
//   moves when both ports request, so a lone requester never changes who
//   wins the next contention. Reset points at instr so data wins first.
// -----------------------------------------------------------------------------
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        // NOTE: every output of this block is given a default before any
        // branch so that no path leaves a signal unassigned (no latch).
        gnt_o  = 2'b00;
        last_d = last_q;

        case (req_i)
            2'b01: gnt_o[PortInstr] = 1'b1;
            2'b10: gnt_o[PortData]  = 1'b1;
            2'b11: begin
                if (last_q == OwnerInstr) begin
                    gnt_o[PortData] = 1'b1;
                    last_d          = OwnerData;
                end else begin
                    gnt_o[PortInstr] = 1'b1;
                    last_d           = OwnerInstr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (!rst_ni) begin
            last_q <= OwnerInstr;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port SRAM between the Ibex instruction and data ports.
//   Grants are combinational and round-robin under contention; the SRAM
//   answers every request after exactly one cycle, so a one-entry response
//   tag is enough to route the answer back to the right port while the next
//   grant is already being issued.
//
//   Parameters
//     MemStart : base address of the SRAM window
//     MemMask  : address bits decoded inside the window
//
//   Ports
//     clk_i, rst_ni                 : clock, asynchronous active-low reset
//     instr_req_i, instr_addr_i     : instruction fetch request
//     instr_gnt_o                   : instruction grant (same cycle)
//     instr_rvalid_o/err_o/rdata_o  : instruction response (one cycle later)
//     data_req_i/we_i/be_i/addr_i/wdata_i : data request
//     data_gnt_o                    : data grant (same cycle)
//     data_rvalid_o/err_o/rdata_o   : data response (one cycle later)
//     mem_req_o/we_o/be_o/addr_o/wdata_o  : SRAM request
//     mem_rvalid_i, mem_rdata_i     : SRAM response
//
//   A missing mem_rvalid_i on an expected in-window response is a protocol
//   violation; it is flagged on that response and then stays set, forcing
//   err on every later response until reset.
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter logic [31:0] MemMask  = 32'h0000_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] req_vec;
    logic [1:0] gnt_vec;

    // Requests are masked while reset is held so no grant or SRAM access
    // can leak out before the block is released.
    assign req_vec = {data_req_i, instr_req_i} & {2{rst_ni}};

    rr_arb2 u_rr_arb2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_vec),
        .gnt_o  (gnt_vec)
    );

    assign instr_gnt_o = gnt_vec[PortInstr];
    assign data_gnt_o  = gnt_vec[PortData];

    logic        any_gnt;
    owner_e      win_owner;
    logic [31:0] win_addr;
    logic        win_hit;

    assign any_gnt   = |gnt_vec;
    assign win_owner = gnt_vec[PortData] ? OwnerData : OwnerInstr;
    assign win_addr  = gnt_vec[PortData] ? data_addr_i : instr_addr_i;
    assign win_hit   = in_window(win_addr, MemStart, MemMask);

    // -------------------------------------------------------------------------
    // SRAM request: only in-window grants reach the memory; everything else
    // leaves the bus at zero so idle and rejected cycles look identical.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;

        if (any_gnt && win_hit) begin
            mem_req_o  = 1'b1;
            mem_addr_o = win_addr;
            if (win_owner == OwnerData) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                // Instruction fetches are always full-word reads.
                mem_be_o = 4'hF;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response tag and sticky protocol error
    // -------------------------------------------------------------------------
    rsp_tag_t tag_q;
    rsp_tag_t tag_d;
    logic     proto_err_q;
    logic     rsp_missing;

    always_comb begin
        tag_d = RspTagIdle;
        if (any_gnt) begin
            tag_d.valid = 1'b1;
            tag_d.owner = win_owner;
            tag_d.err   = ~win_hit;
        end
    end

    // The SRAM must answer every in-window request on the following cycle.
    assign rsp_missing = tag_q.valid & ~tag_q.err & ~mem_rvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q       <= RspTagIdle;
            proto_err_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            proto_err_q <= proto_err_q | rsp_missing;
        end
    end

    // -------------------------------------------------------------------------
    // Response mux: only the tag owner sees rvalid/err/rdata; the other port
    // is held at zero. Error responses return zero data.
    // -------------------------------------------------------------------------
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    assign rsp_err   = tag_q.err | proto_err_q | rsp_missing;
    assign rsp_rdata = rsp_err ? 32'h0 : mem_rdata_i;

    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = 32'h0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = 32'h0;

        if (tag_q.valid) begin
            if (tag_q.owner == OwnerData) begin
                data_rvalid_o = 1'b1;
                data_err_o    = rsp_err;
                data_rdata_o  = rsp_rdata;
            end else begin
                instr_rvalid_o = 1'b1;
                instr_err_o    = rsp_err;
                instr_rdata_o  = rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. Each table row is one clock cycle:
//   the inputs driven in that cycle and every output expected in that same
//   cycle (responses in row N belong to the grant of row N-1). Reset corner
//   cases are covered by short hand-written sequences after the table.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(
        .MemStart (32'h0000_0000),
        .MemMask  (32'h0000_FFFF)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        // inputs
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        mrv;
        logic [31:0] mrd;
        // expected outputs
        logic        igt;
        logic        dgt;
        logic        mreq;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        irv;
        logic        ierr;
        logic [31:0] ird;
        logic        drv;
        logic        derr;
        logic [31:0] drd;
    } vec_t;

    localparam int NumVecs = 17;
    vec_t vecs [NumVecs];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_req_i  = v.ir;
        instr_addr_i = v.ia;
        data_req_i   = v.dr;
        data_we_i    = v.dwe;
        data_be_i    = v.dbe;
        data_addr_i  = v.da;
        data_wdata_i = v.dwd;
        mem_rvalid_i = v.mrv;
        mem_rdata_i  = v.mrd;
    endtask

    task automatic drive_idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic compare_vec(input int i, input vec_t v);
        check($sformatf("v%0d.instr_gnt", i),    32'(instr_gnt_o),    32'(v.igt));
        check($sformatf("v%0d.data_gnt", i),     32'(data_gnt_o),     32'(v.dgt));
        check($sformatf("v%0d.mem_req", i),      32'(mem_req_o),      32'(v.mreq));
        check($sformatf("v%0d.mem_we", i),       32'(mem_we_o),       32'(v.mwe));
        check($sformatf("v%0d.mem_be", i),       32'(mem_be_o),       32'(v.mbe));
        check($sformatf("v%0d.mem_addr", i),     mem_addr_o,          v.maddr);
        check($sformatf("v%0d.mem_wdata", i),    mem_wdata_o,         v.mwd);
        check($sformatf("v%0d.instr_rvalid", i), 32'(instr_rvalid_o), 32'(v.irv));
        check($sformatf("v%0d.instr_err", i),    32'(instr_err_o),    32'(v.ierr));
        check($sformatf("v%0d.instr_rdata", i),  instr_rdata_o,       v.ird);
        check($sformatf("v%0d.data_rvalid", i),  32'(data_rvalid_o),  32'(v.drv));
        check($sformatf("v%0d.data_err", i),     32'(data_err_o),     32'(v.derr));
        check($sformatf("v%0d.data_rdata", i),   data_rdata_o,        v.drd);
    endtask

    initial begin
        //           ir    ia            dr    dwe   dbe   da            dwd           mrv   mrd            igt   dgt   mreq  mwe   mbe   maddr         mwd           irv   ierr  ird           drv   derr  drd
        // idle, first cycle after reset release
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        // instr fetch 0x80, stale mem_rdata must not leak
        vecs[1]  = '{1'b1, 32'h80,       1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'hDEAD,      1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h80,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h13,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h13,       1'b0, 1'b0, 32'h0};
        // lone data read: pointer must not move
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h40,       32'h0,        1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h40,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        // four contended cycles: data, instr, data, instr
        vecs[4]  = '{1'b1, 32'h200,      1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b1, 32'hB0,        1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'hB0};
        vecs[5]  = '{1'b1, 32'h200,      1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b1, 32'hA1,        1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hA1};
        vecs[6]  = '{1'b1, 32'h200,      1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b1, 32'hA2,        1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b1, 1'b0, 32'hA2,      1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h200,      1'b1, 1'b0, 4'hF, 32'h300,      32'h1111_2222, 1'b1, 32'hA3,        1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hA3};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'hA4,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hA4,       1'b0, 1'b0, 32'h0};
        // data write 0x100, be 0011
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3, 32'h100,      32'hA5A5_1234, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h100,      32'hA5A5_1234, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h55};
        // data read just past the window
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0,       1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h77,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
        // instr fetch far outside the window
        vecs[13] = '{1'b1, 32'h2000_0000, 1'b0, 1'b0, 4'h0, 32'h0,       32'h0,        1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h88,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        // last word inside the window
        vecs[15] = '{1'b1, 32'hFFFC,     1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFC,     32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h99,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h99,       1'b0, 1'b0, 32'h0};

        // ---- reset state: requests held high must not produce grants ----
        rst_ni = 1'b0;
        drive_idle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h40;
        @(negedge clk_i);
        check("rst.instr_gnt",    32'(instr_gnt_o),    32'h0);
        check("rst.data_gnt",     32'(data_gnt_o),     32'h0);
        check("rst.mem_req",      32'(mem_req_o),      32'h0);
        check("rst.instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("rst.data_rvalid",  32'(data_rvalid_o),  32'h0);
        check("rst.data_err",     32'(data_err_o),     32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // ---- table ----
        for (int i = 0; i < NumVecs; i++) begin
            drive(vecs[i]);
            @(negedge clk_i);
            compare_vec(i, vecs[i]);
            @(posedge clk_i);
            #1;
        end

        // ---- reset the cycle after an instr grant ----
        drive_idle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        @(negedge clk_i);
        check("rstmid.grant", 32'(instr_gnt_o), 32'h1);
        @(posedge clk_i);
        #1;
        drive_idle();
        rst_ni = 1'b0;
        #1;
        check("rstmid.async_rvalid", 32'(instr_rvalid_o), 32'h0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        data_req_i   = 1'b1;
        @(negedge clk_i);
        check("rstmid.in_rst_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("rstmid.in_rst_gnt",    32'({data_gnt_o, instr_gnt_o}), 32'h0);
        check("rstmid.in_rst_memreq", 32'(mem_req_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        data_addr_i = 32'h44;
        @(negedge clk_i);
        check("rstmid.rel_rvalid",    32'(instr_rvalid_o), 32'h0);
        check("rstmid.rel_data_wins", 32'({data_gnt_o, instr_gnt_o}), 32'h2);
        check("rstmid.rel_mem_addr",  mem_addr_o, 32'h44);
        @(posedge clk_i);
        #1;
        drive_idle();
        mem_rdata_i = 32'h66;
        @(negedge clk_i);
        check("rstmid.data_rvalid",  32'(data_rvalid_o),  32'h1);
        check("rstmid.data_rdata",   data_rdata_o,        32'h66);
        check("rstmid.instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        @(posedge clk_i);
        #1;

        // ---- missing SRAM response raises a sticky error ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h40;
        @(negedge clk_i);
        check("sticky.grant", 32'(instr_gnt_o), 32'h1);
        @(posedge clk_i);
        #1;
        drive_idle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h12;
        @(negedge clk_i);
        check("sticky.rvalid", 32'(instr_rvalid_o), 32'h1);
        check("sticky.err",    32'(instr_err_o),    32'h1);
        check("sticky.rdata",  instr_rdata_o,       32'h0);
        @(posedge clk_i);
        #1;
        drive_idle();
        data_req_i  = 1'b1;
        data_be_i   = 4'hF;
        data_addr_i = 32'h50;
        @(negedge clk_i);
        check("sticky.data_gnt",     32'(data_gnt_o),     32'h1);
        check("sticky.instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        @(posedge clk_i);
        #1;
        drive_idle();
        mem_rdata_i = 32'h34;
        @(negedge clk_i);
        check("sticky.hold_rvalid", 32'(data_rvalid_o), 32'h1);
        check("sticky.hold_err",    32'(data_err_o),    32'h1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h40;
        @(negedge clk_i);
        check("sticky.post_rst_gnt", 32'(instr_gnt_o), 32'h1);
        @(posedge clk_i);
        #1;
        drive_idle();
        mem_rdata_i = 32'h34;
        @(negedge clk_i);
        check("sticky.cleared_rvalid", 32'(instr_rvalid_o), 32'h1);
        check("sticky.cleared_err",    32'(instr_err_o),    32'h0);
        check("sticky.cleared_rdata",  instr_rdata_o,       32'h34);
        @(posedge clk_i);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
